spi_cmd_bridge: RTL and testbench
=================================

SPI_CMD_BRIDGE -- requirements
Module: spi_cmd_bridge

Interface
REQ-001 Parameter ADDR_BYTES, default 3, number of flash address bytes, range 1..4.
REQ-002 Parameter LEN_W, default 8, width of burst length field, range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 recv_ready  input  1  one-cycle pulse: SPI byte received.
REQ-006 recv_data  input  8  received byte; valid when recv_ready=1.
REQ-007 send_data  output  8  byte returned on the next SPI transfer; registered.
REQ-008 led  output  1  debug LED; registered.
REQ-009 flash_addr  output  8*ADDR_BYTES  flash read address; registered.
REQ-010 flash_do_read  output  1  read request level to the flash reader.
REQ-011 flash_setup_done  input  1  flash reader initialised.
REQ-012 flash_data_ready  input  1  one-cycle pulse: flash_data valid.
REQ-013 flash_data  input  8  byte read from flash.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 State updates occur only on cycles with recv_ready=1, except flash handshake and prefetch logic, which run every cycle.
REQ-016 States: IDLE, ADDR, LEN, STREAM, ECHO, plus CSUM when SPI_CMD_CSUM_EN is defined.
REQ-017 IDLE decode: 0x00 -> send 0x00; 0x02 -> toggle led, send 0xAB; 0xCC -> send 0xCC; 0xCD -> send 0xCD, go to ECHO; 0x10+i (i<ADDR_BYTES) -> send flash_addr byte i (i=0 is LSB); 0x01 -> send ADDR_BYTES, clear the address register, go to ADDR; any other byte -> send 0x00.
REQ-018 ECHO: send recv_data, return to IDLE.
REQ-019 ADDR: shift the address in MSB-first; remaining-byte count decrements; send the remaining count after decrement; go to LEN after ADDR_BYTES bytes.
REQ-020 LEN: burst length = recv_data[LEN_W-1:0]+1 (range 1..2^LEN_W); load flash_addr from the address register; send 0xFE; go to STREAM.
REQ-021 Prefetch: a one-byte holding buffer with a valid flag; when in STREAM, the buffer is empty, remaining>0, flash_setup_done=1 and flash_do_read=0, assert flash_do_read.
REQ-022 flash_do_read is held until a flash_data_ready pulse; on that pulse: capture flash_data, set valid, deassert flash_do_read, increment flash_addr modulo 2^(8*ADDR_BYTES).
REQ-023 STREAM, per recv_ready: if valid=0, send 0xFE; if valid=1 and the marker has not been sent, send 0xFF and mark it sent; otherwise send the buffer byte, clear valid, decrement remaining.
REQ-024 Only one marker is sent per burst; later underruns send 0xFE and then resume data without a new marker.
REQ-025 When the last data byte is sent: go to CSUM if enabled, else IDLE.
REQ-026 If flash_data_ready and a STREAM consume occur in the same cycle, the consume uses the old buffer state; the new byte is captured the same cycle.
REQ-027 A flash_data_ready pulse arriving outside an outstanding request is ignored.
REQ-028 While flash_setup_done=0, no read is issued; STREAM sends 0xFE.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, send_data 0x00, led 0, flash_addr 0, flash_do_read 0, busy 0, valid 0, marker 0, remaining 0, checksum 0.
REQ-030 Reset mid-burst abandons the request with no flush; any later flash_data_ready is ignored per REQ-027.

Configuration
REQ-031 Macro SPI_CMD_CSUM_EN defined: an 8-bit XOR of all data bytes in the burst, cleared in LEN, is sent once in CSUM, followed by a return to IDLE.
REQ-032 Macro SPI_CMD_CSUM_EN undefined: no CSUM state and no checksum logic; STREAM returns directly to IDLE.

Verification
REQ-033 Reset, then bytes 0x02,0x02 -> send_data 0xAB both times; led 1 then 0.
REQ-034 Bytes 0xCD,0x5A -> send_data 0xCD then 0x5A; then 0x77 -> 0x00 (back in IDLE).
REQ-035 Bytes 0x01,0x00,0x10,0x20,0x02, flash supplying 0x11,0x22,0x33 -> address 0x001020, replies 3,2,1,0 then 0xFE; subsequent polls give 0xFE*, 0xFF, 0x11, 0x22, 0x33, then 0x00 (0x00 is the checksum when enabled); then 0x10 -> 0x23.
REQ-036 ADDR_BYTES=3, address 0xFFFFFF, length byte 0x01 -> reads at 0xFFFFFF then 0x000000; flash_addr ends at 0x000001.
REQ-037 flash_setup_done held 0 for 20 polls during STREAM -> all 20 replies are 0xFE and flash_do_read stays 0.
REQ-038 rst asserted while flash_do_read=1, followed by a flash_data_ready pulse -> state IDLE, valid 0, the next 0x10 command returns 0x00.

Source files
------------

// File: rtl/spi_cmd_bridge.sv
// spi_cmd_bridge: SPI byte-command decoder feeding a flash reader with a one-byte prefetch buffer.
// Define SPI_CMD_CSUM_EN to append an XOR checksum byte after each burst.
module spi_cmd_bridge #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    recv_ready,
  input  logic [7:0]              recv_data,
  output logic [7:0]              send_data,
  output logic                    led,
  output logic [8*ADDR_BYTES-1:0] flash_addr,
  output logic                    flash_do_read,
  input  logic                    flash_setup_done,
  input  logic                    flash_data_ready,
  input  logic [7:0]              flash_data,
  output logic                    busy
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int RW = LEN_W + 1;
  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, STREAM, ECHO
`ifdef SPI_CMD_CSUM_EN
    , CSUM
`endif
  } state_t;
`ifdef SPI_CMD_CSUM_EN
  localparam state_t DONE = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t DONE = IDLE;
`endif
  state_t state_q, state_d;
  logic [7:0] send_q, send_d, buf_q, buf_d;
  logic led_q, led_d, valid_q, valid_d, mark_q, mark_d, rd_q, rd_d;
  logic [AW-1:0] faddr_q, faddr_d, addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  always_comb begin
    state_d = state_q;
    send_d = send_q;
    led_d = led_q;
    faddr_d = faddr_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    buf_d = buf_q;
    valid_d = valid_q;
    mark_d = mark_q;
    rd_d = rd_q;
`ifdef SPI_CMD_CSUM_EN
    csum_d = csum_q;
`endif
    if (recv_ready) begin
      case (state_q)
        IDLE: begin
          send_d = 8'h00;
          if (recv_data == 8'h01) begin
            send_d = 8'(ADDR_BYTES);
            addr_d = '0;
            cnt_d = 3'(ADDR_BYTES);
            state_d = ADDR;
          end else if (recv_data == 8'h02) begin
            led_d = !led_q;
            send_d = 8'hAB;
          end else if (recv_data == 8'hCC) begin
            send_d = 8'hCC;
          end else if (recv_data == 8'hCD) begin
            send_d = 8'hCD;
            state_d = ECHO;
          end else if (recv_data >= 8'h10 && recv_data < 8'(16 + ADDR_BYTES)) begin
            send_d = 8'(faddr_q >> {recv_data[1:0], 3'b000});
          end
        end
        ECHO: begin
          send_d = recv_data;
          state_d = IDLE;
        end
        ADDR: begin
          addr_d = AW'({addr_q, recv_data});
          cnt_d = cnt_q - 3'd1;
          send_d = 8'(cnt_d);
          state_d = (cnt_d == 3'd0) ? LEN : ADDR;
        end
        LEN: begin
          rem_d = RW'(recv_data[LEN_W-1:0]) + RW'(1);
          faddr_d = addr_q;
          valid_d = 1'b0;
          mark_d = 1'b0;
          send_d = 8'hFE;
          state_d = STREAM;
`ifdef SPI_CMD_CSUM_EN
          csum_d = 8'h00;
`endif
        end
        STREAM: begin
          if (!valid_q) begin
            send_d = 8'hFE;
          end else if (!mark_q) begin
            send_d = 8'hFF;
            mark_d = 1'b1;
          end else begin
            send_d = buf_q;
            valid_d = 1'b0;
            rem_d = rem_q - RW'(1);
            state_d = (rem_q == RW'(1)) ? DONE : STREAM;
`ifdef SPI_CMD_CSUM_EN
            csum_d = csum_q ^ buf_q;
`endif
          end
        end
`ifdef SPI_CMD_CSUM_EN
        CSUM: begin
          send_d = csum_q;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    if (state_q == STREAM && !valid_q && rem_q != '0 && flash_setup_done && !rd_q) rd_d = 1'b1;
    // Capture after the consume above so a same-cycle delivery refills the buffer.
    if (rd_q && flash_data_ready) begin
      buf_d = flash_data;
      valid_d = 1'b1;
      rd_d = 1'b0;
      faddr_d = faddr_q + AW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      send_q <= 8'h00;
      led_q <= 1'b0;
      faddr_q <= '0;
      addr_q <= '0;
      cnt_q <= 3'd0;
      rem_q <= '0;
      buf_q <= 8'h00;
      valid_q <= 1'b0;
      mark_q <= 1'b0;
      rd_q <= 1'b0;
`ifdef SPI_CMD_CSUM_EN
      csum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      send_q <= send_d;
      led_q <= led_d;
      faddr_q <= faddr_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      buf_q <= buf_d;
      valid_q <= valid_d;
      mark_q <= mark_d;
      rd_q <= rd_d;
`ifdef SPI_CMD_CSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign send_data = send_q;
  assign led = led_q;
  assign flash_addr = faddr_q;
  assign flash_do_read = rd_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_spi_cmd_bridge.sv
// tb_spi_cmd_bridge: scoreboard bench; a command-level model predicts every SPI reply.
module tb_spi_cmd_bridge;
  logic clk = 0, rst = 1, recv_ready = 0, flash_setup_done = 1, flash_data_ready = 0;
  logic [7:0] recv_data = 0, flash_data = 0, send_data;
  logic led, flash_do_read, busy;
  logic [23:0] flash_addr;
  int errors = 0, checks = 0;
  logic [7:0] expq[$];
  logic [7:0] bufq[$];
  int mode = 0, mcnt = 0, mrem = 0;
  bit mled = 0, marker = 0, pend = 0, chk_pend = 0;
  int dly = 0;
  logic [23:0] maddr = 0, mfaddr = 0;
  logic [7:0] mcsum = 0;
  spi_cmd_bridge dut (
    .clk(clk), .rst(rst), .recv_ready(recv_ready), .recv_data(recv_data),
    .send_data(send_data), .led(led), .flash_addr(flash_addr),
    .flash_do_read(flash_do_read), .flash_setup_done(flash_setup_done),
    .flash_data_ready(flash_data_ready), .flash_data(flash_data), .busy(busy)
  );
  always #5 clk = !clk;
  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h001020: return 8'h11;
      24'h001021: return 8'h22;
      24'h001022: return 8'h33;
      default: return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  always @(posedge clk) chk_pend <= recv_ready && !rst;
  always @(negedge clk) begin
    if (chk_pend) begin
      logic [7:0] e;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL reply: got %02h with no expected value queued", send_data);
      end else begin
        e = expq.pop_front();
        if (send_data !== e) begin
          errors++;
          $display("FAIL reply: got %02h want %02h (mode %0d)", send_data, e, mode);
        end
      end
    end
  end
  task automatic model(input logic [7:0] b, output logic [7:0] r);
    int i;
    r = 8'h00;
    case (mode)
      0: begin
        i = int'(b) - 16;
        if (b == 8'h01) begin r = 8'd3; maddr = 0; mcnt = 3; mode = 1; end
        else if (b == 8'h02) begin mled = !mled; r = 8'hAB; end
        else if (b == 8'hCC) r = 8'hCC;
        else if (b == 8'hCD) begin r = 8'hCD; mode = 4; end
        else if (i >= 0 && i < 3) r = 8'(mfaddr >> (8 * i));
      end
      1: begin
        maddr = {maddr[15:0], b};
        mcnt--;
        r = 8'(mcnt);
        if (mcnt == 0) mode = 2;
      end
      2: begin
        mrem = int'(b) + 1; mfaddr = maddr; marker = 0; mcsum = 0;
        r = 8'hFE; mode = 3;
      end
      3: begin
        if (bufq.size() == 0) r = 8'hFE;
        else if (!marker) begin r = 8'hFF; marker = 1; end
        else begin
          r = bufq.pop_front();
          mcsum ^= r;
          mrem--;
`ifdef SPI_CMD_CSUM_EN
          if (mrem == 0) mode = 5;
`else
          if (mrem == 0) mode = 0;
`endif
        end
      end
      4: begin r = b; mode = 0; end
      default: begin r = mcsum; mode = 0; end
    endcase
  endtask
  // One clock: optional SPI byte plus the flash responder; model sees the old buffer before any delivery.
  task automatic step(input bit p, input logic [7:0] b);
    logic [7:0] e;
    recv_ready = p;
    recv_data = b;
    flash_data_ready = 0;
    if (p) begin
      model(b, e);
      expq.push_back(e);
    end
    if (pend) begin
      if (dly == 0) begin
        flash_data_ready = 1;
        flash_data = mem(flash_addr);
        bufq.push_back(mem(mfaddr));
        mfaddr++;
        pend = 0;
      end else dly--;
    end else if (flash_do_read) begin
      pend = 1;
      dly = $urandom_range(0, 3);
    end else if ($urandom_range(0, 15) == 0) begin
      flash_data_ready = 1;
      flash_data = 8'($urandom);
    end
    @(negedge clk);
    recv_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    recv_ready = 0;
    flash_data_ready = 0;
    @(negedge clk);
    rst = 0;
    mode = 0; mled = 0; mfaddr = 0; maddr = 0; mrem = 0; marker = 0; mcsum = 0; pend = 0;
    bufq.delete();
  endtask
  task automatic burst_start(input logic [23:0] a, input logic [7:0] lb);
    step(1, 8'h01);
    for (int i = 2; i >= 0; i--) step(1, a[8*i+:8]);
    step(1, lb);
  endtask
  task automatic burst_finish();
    int n = 0;
    while (mode != 0 && n < 3000) begin
      step($urandom_range(0, 2) != 0, 8'($urandom));
      n++;
    end
    if (mode != 0) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: still streaming after %0d cycles", n);
    end
    step(0, 8'h00);
    chk("busy_after_burst", 32'(busy), 32'd0);
  endtask
  task automatic read_addr();
    for (int i = 0; i < 3; i++) step(1, 8'(16 + i));
  endtask
  initial begin
    do_reset();
    chk("rst_send", 32'(send_data), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(flash_do_read), 0);
    chk("rst_addr", 32'(flash_addr), 0);
    step(1, 8'h02);
    chk("led_on", 32'(led), 1);
    step(1, 8'h02);
    chk("led_off", 32'(led), 0);
    step(1, 8'hCD);
    chk("echo_busy", 32'(busy), 1);
    step(1, 8'h5A);
    step(1, 8'h77);
    burst_start(24'h001020, 8'h02);
    burst_finish();
    step(1, 8'h00);
    read_addr();
    chk("addr_after_035", 32'(flash_addr), 32'h001023);
    burst_start(24'hFFFFFF, 8'h01);
    burst_finish();
    chk("addr_wrap", 32'(flash_addr), 32'h000001);
    read_addr();
    flash_setup_done = 0;
    burst_start(24'h00ABC0, 8'h03);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom));
      chk("no_read_setup0", 32'(flash_do_read), 0);
    end
    flash_setup_done = 1;
    burst_finish();
    read_addr();
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 6; j++) begin
        logic [7:0] c;
        c = 8'($urandom);
        case ($urandom_range(0, 4))
          0: c = 8'h02;
          1: c = 8'hCC;
          2: c = 8'hCD;
          3: c = 8'(16 + $urandom_range(0, 3));
          default: if (c == 8'h01) c = 8'h00;
        endcase
        step($urandom_range(0, 3) != 0, c);
      end
      if (mode == 4) step(1, 8'($urandom));
      chk("led_track", 32'(led), 32'(mled));
      burst_start(24'($urandom), 8'($urandom_range(0, 15)));
      burst_finish();
      read_addr();
      chk("addr_track", 32'(flash_addr), 32'(mfaddr));
    end
    burst_start(24'h123456, 8'h05);
    for (int i = 0; i < 50 && !flash_do_read; i++) step(0, 8'h00);
    chk("rd_before_rst", 32'(flash_do_read), 1);
    do_reset();
    flash_data_ready = 1;
    flash_data = 8'h99;
    @(negedge clk);
    flash_data_ready = 0;
    chk("busy_after_rst", 32'(busy), 0);
    chk("rd_after_rst", 32'(flash_do_read), 0);
    step(1, 8'h10);
    step(1, 8'hCC);
    repeat (3) step(0, 8'h00);
    chk("queue_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
